mac_switch_np: RTL and testbench
================================

// Module: mac_switch_np
// PURPOSE
//  PORT_NUM-port L2 forwarding engine between the shared MAC_DEC header/body FIFOs and the per-port TX FRAME_FIFOs.
//  Learns source MAC -> ingress port in a direct-mapped table and forwards each frame to its learned port.
//  Floods broadcast, multicast and unknown-destination frames; drops frames addressed back to their ingress port.
//  Successor of the fixed 4-port switch core: port count, table depth and aging are parametrised.
// PARAMETERS
//  PORT_NUM        4            number of switch ports (2..16); PORT_W = max(1, $clog2(PORT_NUM))
//  HEADER_DWIDTH   128          header word width. Fields: [47:0] dst MAC, [95:48] src MAC, [96+:PORT_W] ingress port
//  TABLE_ADDR_LEN  3            learn table holds 2**TABLE_ADDR_LEN entries
//  AGE_TICKS       100_000_000  aging period in clk cycles; used only when MAC_AGING_EN is defined
// PORTS
//  clk           in   1                system clock (100 MHz)
//  arst_n        in   1                asynchronous active-low reset
//  h_fifo_dout   in   HEADER_DWIDTH    header word; valid 1 cycle after h_fifo_rden
//  h_fifo_empty  in   1                header FIFO empty
//  h_fifo_rden   out  1                header FIFO read strobe
//  b_fifo_dout   in   8                body byte; valid 1 cycle after b_fifo_rden
//  b_fifo_empty  in   1                body FIFO empty
//  b_fifo_del    in   1                end-of-frame; qualifies the b_fifo_dout byte it accompanies
//  b_fifo_rden   out  1                body FIFO read strobe
//  o_fifo_din    out  8                byte to TX FIFOs (shared by all ports)
//  o_fifo_del    out  1                end-of-frame; asserted together with the last-byte write
//  o_fifo_afull  in   PORT_NUM         per-port TX FIFO almost-full
//  o_fifo_wren   out  PORT_NUM         per-port write enable (one-hot or flood mask)
//  mask_port     in   PORT_NUM         1 = port excluded from all forwarding, including flood
//  drop_cnt      out  16               number of dropped frames; wraps at 16'hFFFF
//  busy          out  1                high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; all table entries invalid; aging counter 0.
//  Both FIFOs are non-FWFT with 1-cycle read latency. At most one read is outstanding at a time.
//  FSM states:
//   IDLE:   when !h_fifo_empty, pulse h_fifo_rden and go to HDR.
//   HDR:    register the header and go to LKUP.
//   LKUP:   hash(mac) = XOR of the 48-bit MAC split into TABLE_ADDR_LEN-bit slices (upper slice zero-padded).
//           Read the table entry at hash(dst); learn {src, port} at hash(src); any collision overwrites.
//           Read-before-write: when both hashes match, the lookup uses the pre-write entry.
//           No learning when src[40]=1 (multicast source) or ingress port >= PORT_NUM.
//           dest computation:
//             dst[40]=1 or table miss -> flood to ~onehot(src_port) & ~mask_port
//             hit -> onehot(entry port) & ~mask_port
//           Go to DROP if dest==0, the hit port equals the ingress port, or the ingress port is invalid; else go to WAIT.
//   WAIT:   stay until (o_fifo_afull & dest)==0, then go to XFER. afull is sampled only here.
//           TX FIFO afull threshold guarantees space for 1518 bytes; afull is ignored mid-frame.
//   XFER:   b_fifo_rden=!b_fifo_empty && no del seen yet.
//           1 cycle after each read: o_fifo_din=b_fifo_dout, o_fifo_wren=dest, o_fifo_del=b_fifo_del.
//           The read that returns del ends the frame; go to IDLE on the cycle after the del write.
//   DROP:   same reads as XFER with o_fifo_wren=0; drop_cnt+1 on the del byte; then go to IDLE.
//  Latency: h_fifo_rden at cycle 0 -> first b_fifo_rden no earlier than cycle 3 -> first write at cycle 4.
//  Back-to-back frames: the next h_fifo_rden comes no earlier than the cycle after the del write.
//  Body FIFO empty mid-frame: rden stays low and no write occurs; resume when data returns.
//  mask_port is sampled in LKUP only; changes mid-frame do not affect the frame in flight.
//  Reset mid-frame: immediate return to IDLE and table cleared; TX/body FIFOs share arst_n.
// CONFIGURATION
//  MAC_AGING_EN defined:
//   each entry carries an active bit, set on learn; a free-running counter ticks every AGE_TICKS cycles.
//   On a tick, valid&=active for all entries, then active is cleared.
//   A learn on the same cycle as a tick wins for that entry (valid=1, active=1).
//  MAC_AGING_EN undefined: entries never expire; no counter or active bits are synthesised.
// STRUCTURE
//  Package mac_switch_pkg: header field offsets, FSM state encoding, PORT_W function, mac_hash function.
//  Sub-module mac_learn_table: flop array with 1 async read port and 1 write port, valid bits, optional aging logic.
//  Top-level mac_switch_np: FSM, dest-mask computation, datapath, drop counter.
// TESTING
//  T1: learn src AA:..:01 on p1; then dst AA:..:01 from p0 -> wren=4'b0010 only; 64 bytes out, del on byte 64.
//  T2: dst FF:FF:FF:FF:FF:FF from p2 with mask_port=4'b0001 -> wren=4'b1010 on every byte.
//  T3: dst learned on p3, frame ingress p3 -> no wren, body fully read, drop_cnt 0->1.
//  T4: o_fifo_afull[1]=1 at WAIT for 20 cycles on a p1-bound frame -> no b_fifo_rden until afull clears, then normal.
//  T5: b_fifo_empty pulsed high 5 cycles mid-frame -> output gap, no duplicate or lost byte; reset mid-XFER -> outputs 0, next lookup floods.
//  T6 (MAC_AGING_EN, AGE_TICKS=100): learn, idle 2 ticks, send to that dst -> flooded; learn on tick cycle -> still hit.

Source files
------------

// File: rtl/mac_switch_pkg.sv
// Shared definitions for the mac_switch_np forwarding engine: header field
// offsets, FSM encoding, port-index width and the learn-table hash.
package mac_switch_pkg;

   localparam int MAC_W     = 48;
   localparam int DST_LSB   = 0;
   localparam int SRC_LSB   = 48;
   localparam int PORT_LSB  = 96;
   localparam int MCAST_BIT = 40;   // I/G bit of the first octet

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LKUP,
      S_WAIT,
      S_XFER,
      S_DROP
   } state_t;

   // Width of a port index; never narrower than one bit.
   function automatic int port_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // XOR-fold of the MAC into aw-bit slices (top slice zero-padded).
   // Bits above aw in the result are always zero.
   function automatic logic [15:0] mac_hash(input logic [MAC_W-1:0] mac, input int aw);
      logic [15:0] h;
      logic [3:0]  idx;
      h = '0;
      for (int i = 0; i < MAC_W; i++) begin
         idx    = 4'(i % aw);
         h[idx] = h[idx] ^ mac[i];
      end
      return h;
   endfunction

endpackage

// File: rtl/mac_learn_table.sv
// Direct-mapped MAC learn table: one asynchronous read port, one write port,
// per-entry valid bits. With MAC_AGING_EN defined, each entry also carries an
// active bit and a free-running counter expires entries not refreshed between
// two consecutive ticks.
module mac_learn_table
   import mac_switch_pkg::*;
#(
   parameter int AW        = 3,
   parameter int PW        = 2,
   parameter int AGE_TICKS = 100_000_000
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [AW-1:0]    rd_addr,
   output logic             rd_valid,
   output logic [MAC_W-1:0] rd_mac,
   output logic [PW-1:0]    rd_port,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [MAC_W-1:0] wr_mac,
   input  logic [PW-1:0]    wr_port
);

   localparam int DEPTH = 1 << AW;

   logic [DEPTH-1:0][MAC_W-1:0] mac_q;
   logic [DEPTH-1:0][PW-1:0]    port_q;
   logic [DEPTH-1:0]            vld_q;
   logic [DEPTH-1:0]            wsel;

   assign wsel     = wr_en ? (DEPTH'(1) << wr_addr) : '0;
   assign rd_valid = vld_q[rd_addr];
   assign rd_mac   = mac_q[rd_addr];
   assign rd_port  = port_q[rd_addr];

   // Entry payload; meaningless until its valid bit is set, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wsel[i]) begin
            mac_q[i]  <= wr_mac;
            port_q[i] <= wr_port;
         end
      end
   end

`ifdef MAC_AGING_EN
   localparam int CW = $clog2(AGE_TICKS + 1);

   logic [CW-1:0]    age_cnt;
   logic [DEPTH-1:0] act_q;
   logic             tick;

   assign tick = (age_cnt == CW'(AGE_TICKS - 1));

   // Free-running aging period counter.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)   age_cnt <= '0;
      else if (tick) age_cnt <= '0;
      else           age_cnt <= age_cnt + 1'b1;
   end

   // Tick expires idle entries; a learn in the same cycle keeps its entry alive.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         vld_q <= '0;
         act_q <= '0;
      end else if (tick) begin
         vld_q <= (vld_q & act_q) | wsel;
         act_q <= wsel;
      end else begin
         vld_q <= vld_q | wsel;
         act_q <= act_q | wsel;
      end
   end
`else
   localparam int UNUSED_AGE_TICKS = AGE_TICKS;

   // Entries stay valid until reset.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) vld_q <= '0;
      else         vld_q <= vld_q | wsel;
   end
`endif

endmodule

// File: rtl/mac_switch_np.sv
// mac_switch_np: PORT_NUM-port L2 forwarding engine. Pops one header, learns
// the source MAC, looks up the destination and streams the body bytes to the
// selected TX FIFOs (or discards them). Optional aging: MAC_AGING_EN.
module mac_switch_np
   import mac_switch_pkg::*;
#(
   parameter int PORT_NUM       = 4,
   parameter int HEADER_DWIDTH  = 128,
   parameter int TABLE_ADDR_LEN = 3,
   parameter int AGE_TICKS      = 100_000_000
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
   input  logic                     h_fifo_empty,
   output logic                     h_fifo_rden,
   input  logic [7:0]               b_fifo_dout,
   input  logic                     b_fifo_empty,
   input  logic                     b_fifo_del,
   output logic                     b_fifo_rden,
   output logic [7:0]               o_fifo_din,
   output logic                     o_fifo_del,
   input  logic [PORT_NUM-1:0]      o_fifo_afull,
   output logic [PORT_NUM-1:0]      o_fifo_wren,
   input  logic [PORT_NUM-1:0]      mask_port,
   output logic [15:0]              drop_cnt,
   output logic                     busy
);

   localparam int PW = port_w(PORT_NUM);
   localparam int HW = PORT_LSB + PW;
   localparam int AW = TABLE_ADDR_LEN;

   state_t              state_q, state_d;
   logic [HW-1:0]       hdr_q;
   logic [PORT_NUM-1:0] dest_q, dest_d;
   logic                rd_pend_q;
   logic [15:0]         drop_q;

   logic [MAC_W-1:0]    dst, src, rd_mac;
   logic [PW-1:0]       src_port, rd_port;
   logic [15:0]         dst_hf, src_hf;
   logic                rd_valid, hit, flood, hairpin, port_ok, learn, eof, wr_act;
   logic [PORT_NUM-1:0] src_oh, hit_oh;

   assign dst      = hdr_q[DST_LSB +: MAC_W];
   assign src      = hdr_q[SRC_LSB +: MAC_W];
   assign src_port = hdr_q[PORT_LSB +: PW];
   assign dst_hf   = mac_hash(dst, AW);
   assign src_hf   = mac_hash(src, AW);

   // Lookup and learn share the LKUP cycle; the write lands at the clock edge,
   // so a lookup hitting the same slot sees the old entry.
   assign port_ok = (int'(src_port) < PORT_NUM);
   assign learn   = (state_q == S_LKUP) && !src[MCAST_BIT] && port_ok;

   mac_learn_table #(
      .AW       (AW),
      .PW       (PW),
      .AGE_TICKS(AGE_TICKS)
   ) u_tbl (
      .clk     (clk),
      .arst_n  (arst_n),
      .rd_addr (dst_hf[AW-1:0]),
      .rd_valid(rd_valid),
      .rd_mac  (rd_mac),
      .rd_port (rd_port),
      .wr_en   (learn),
      .wr_addr (src_hf[AW-1:0]),
      .wr_mac  (src),
      .wr_port (src_port)
   );

   assign hit     = rd_valid && (rd_mac == dst);
   assign flood   = dst[MCAST_BIT] || !hit;
   assign hairpin = !flood && (rd_port == src_port);
   assign src_oh  = PORT_NUM'(1) << src_port;
   assign hit_oh  = PORT_NUM'(1) << rd_port;
   assign dest_d  = flood ? (~src_oh & ~mask_port) : (hit_oh & ~mask_port);

   // A body byte is on b_fifo_dout the cycle after its read; del marks the last.
   assign eof    = rd_pend_q && b_fifo_del;
   assign wr_act = rd_pend_q && (state_q == S_XFER);

   assign o_fifo_wren = wr_act ? dest_q : '0;
   assign o_fifo_din  = wr_act ? b_fifo_dout : 8'h00;
   assign o_fifo_del  = wr_act && b_fifo_del;
   assign drop_cnt    = drop_q;
   assign busy        = (state_q != S_IDLE);

   // Next state and FIFO read strobes; reads stop on the cycle del returns.
   always_comb begin
      state_d     = state_q;
      h_fifo_rden = 1'b0;
      b_fifo_rden = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!h_fifo_empty) begin
               h_fifo_rden = 1'b1;
               state_d     = S_HDR;
            end
         end
         S_HDR:  state_d = S_LKUP;
         S_LKUP: state_d = (dest_d == '0 || hairpin || !port_ok) ? S_DROP : S_WAIT;
         S_WAIT: begin
            if ((o_fifo_afull & dest_q) == '0) begin
               b_fifo_rden = !b_fifo_empty;
               state_d     = S_XFER;
            end
         end
         S_XFER, S_DROP: begin
            b_fifo_rden = !b_fifo_empty && !eof;
            if (eof) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, captured header, frame destination and pending-read flag.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= S_IDLE;
         hdr_q     <= '0;
         dest_q    <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= b_fifo_rden;
         if (state_q == S_HDR)  hdr_q  <= h_fifo_dout[HW-1:0];
         if (state_q == S_LKUP) dest_q <= dest_d;
      end
   end

   // Count discarded frames on their last byte; wraps naturally.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)                         drop_q <= '0;
      else if (state_q == S_DROP && eof)   drop_q <= drop_q + 16'd1;
   end

   logic unused_ok;
   assign unused_ok = ^{h_fifo_dout[HEADER_DWIDTH-1:HW], dst_hf[15:AW], src_hf[15:AW]};

endmodule

// File: tb/tb_mac_switch_np.sv
// Directed bench for mac_switch_np (4 ports, 8-entry table). Header and body
// FIFOs are behavioural non-FWFT queues; TX writes are logged and compared
// against hand-computed masks and byte sequences.
module tb_mac_switch_np;

   logic         clk = 1'b0;
   logic         arst_n = 1'b0;
   logic [127:0] h_fifo_dout;
   logic         h_fifo_empty = 1'b1;
   logic         h_fifo_rden;
   logic [7:0]   b_fifo_dout;
   logic         b_fifo_empty = 1'b1;
   logic         b_fifo_del;
   logic         b_fifo_rden;
   logic [7:0]   o_fifo_din;
   logic         o_fifo_del;
   logic [3:0]   o_fifo_afull = 4'b0;
   logic [3:0]   o_fifo_wren;
   logic [3:0]   mask_port = 4'b0;
   logic [15:0]  drop_cnt;
   logic         busy;

   always #5 clk = ~clk;

   mac_switch_np #(
      .PORT_NUM(4), .HEADER_DWIDTH(128), .TABLE_ADDR_LEN(3), .AGE_TICKS(100)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .h_fifo_dout(h_fifo_dout), .h_fifo_empty(h_fifo_empty), .h_fifo_rden(h_fifo_rden),
      .b_fifo_dout(b_fifo_dout), .b_fifo_empty(b_fifo_empty), .b_fifo_del(b_fifo_del),
      .b_fifo_rden(b_fifo_rden),
      .o_fifo_din(o_fifo_din), .o_fifo_del(o_fifo_del), .o_fifo_afull(o_fifo_afull),
      .o_fifo_wren(o_fifo_wren), .mask_port(mask_port), .drop_cnt(drop_cnt), .busy(busy)
   );

   // MACs; hashes (3-bit fold): A=2 B=6 C=7 D=0 E=6 F=0 G=1 H=5
   localparam logic [47:0] MAC_A = 48'hAA00_0000_0001;
   localparam logic [47:0] MAC_B = 48'h0200_0000_0002;
   localparam logic [47:0] MAC_C = 48'h0200_0000_0003;
   localparam logic [47:0] MAC_D = 48'h0200_0000_0004;
   localparam logic [47:0] MAC_E = 48'h0200_0000_0010;
   localparam logic [47:0] MAC_F = 48'h0200_0000_0020;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [127:0] hq[$];
   logic [8:0]   bq[$];
   logic [12:0]  wq[$];
   logic [8:0]   be;
   int           rd_cnt = 0;
   int           urun = 0;
   int           ecnt = 0;
   logic         force_empty = 1'b0;

   // Non-FWFT FIFO models: data appears the cycle after the read strobe.
   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         h_fifo_dout <= '0;
         b_fifo_dout <= '0;
         b_fifo_del  <= 1'b0;
         ecnt        <= 0;
      end else begin
         ecnt <= ecnt + 1;
         if (h_fifo_rden && hq.size() > 0) h_fifo_dout <= hq.pop_front();
         if (b_fifo_rden) begin
            rd_cnt <= rd_cnt + 1;
            if (bq.size() > 0) begin
               be = bq.pop_front();
               b_fifo_dout <= be[7:0];
               b_fifo_del  <= be[8];
            end else urun <= urun + 1;
         end
      end
   end

   // Empty flags and TX write log, evaluated away from the active edge.
   always @(negedge clk) begin
      h_fifo_empty = (hq.size() == 0);
      b_fifo_empty = force_empty || (bq.size() == 0);
      if (o_fifo_wren != 4'b0 || o_fifo_del) wq.push_back({o_fifo_wren, o_fifo_del, o_fifo_din});
   end

   task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input logic [1:0] port,
                             input int n, input logic [7:0] seed);
      logic [127:0] h;
      h = '0;
      h[47:0]  = dst;
      h[95:48] = src;
      h[97:96] = port;
      hq.push_back(h);
      h_fifo_empty = 1'b0;
      for (int i = 0; i < n; i++) bq.push_back({(i == n - 1), 8'(seed + i)});
      b_fifo_empty = force_empty;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (!(hq.size() == 0 && bq.size() == 0 && !busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_to"}, 32'(k < 3000), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_out(input string tag, input int n, input logic [3:0] mask, input logic [7:0] seed);
      int errs;
      errs = 0;
      chk({tag, "_n"}, wq.size(), n);
      foreach (wq[i]) if (wq[i] !== {mask, (i == n - 1), 8'(seed + i)}) errs++;
      chk({tag, "_data"}, errs, 0);
      wq.delete();
   endtask

   task automatic wait_writes(input string tag, input int n);
      int k;
      k = 0;
      while (wq.size() < n && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_wto"}, 32'(k < 500), 1);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      int r0, w0;
      repeat (2) @(negedge clk);
      chk("rst_out", {h_fifo_rden, b_fifo_rden, o_fifo_wren, o_fifo_del, o_fifo_din, busy}, 0);
      chk("rst_drop", drop_cnt, 0);
      arst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", busy, 0);

      // Learn A on p1 (dst unknown -> flood), then forward to A from p0.
      push_frame(MAC_B, MAC_A, 2'd1, 8, 8'h10);
      wait_done("t1l");
      check_out("t1l", 8, 4'b1101, 8'h10);
      push_frame(MAC_A, MAC_C, 2'd0, 64, 8'h40);
      wait_done("t1");
      check_out("t1", 64, 4'b0010, 8'h40);

      // Broadcast from p2 with p0 masked.
      mask_port = 4'b0001;
      push_frame(BCAST, MAC_D, 2'd2, 16, 8'h80);
      wait_done("t2");
      check_out("t2", 16, 4'b1010, 8'h80);
      mask_port = 4'b0000;

      // Learn E on p3, then a frame to E arriving on p3 is dropped.
      push_frame(MAC_B, MAC_E, 2'd3, 4, 8'h20);
      wait_done("t3l");
      check_out("t3l", 4, 4'b0111, 8'h20);
      chk("t3_cnt0", drop_cnt, 0);
      r0 = rd_cnt;
      push_frame(MAC_E, MAC_F, 2'd3, 24, 8'h30);
      wait_done("t3");
      check_out("t3", 0, 4'b0000, 8'h00);
      chk("t3_rd", rd_cnt - r0, 24);
      chk("t3_cnt1", drop_cnt, 1);

      // Every flood target masked -> empty mask -> dropped.
      mask_port = 4'b1011;
      push_frame(BCAST, MAC_D, 2'd2, 6, 8'h00);
      wait_done("t3m");
      check_out("t3m", 0, 4'b0000, 8'h00);
      chk("t3m_cnt", drop_cnt, 2);
      mask_port = 4'b0000;

      // Destination port almost-full holds the frame in WAIT.
      o_fifo_afull = 4'b0010;
      r0 = rd_cnt;
      push_frame(MAC_A, MAC_C, 2'd0, 16, 8'h50);
      repeat (22) @(negedge clk);
      chk("t4_rd", rd_cnt - r0, 0);
      chk("t4_busy", busy, 1);
      chk("t4_wr", wq.size(), 0);
      o_fifo_afull = 4'b0000;
      wait_done("t4");
      check_out("t4", 16, 4'b0010, 8'h50);

      // Body FIFO runs dry mid-frame for 5 cycles.
      push_frame(MAC_A, MAC_C, 2'd0, 32, 8'h60);
      wait_writes("t5", 10);
      force_empty  = 1'b1;
      b_fifo_empty = 1'b1;
      r0 = rd_cnt;
      w0 = wq.size();
      repeat (5) @(negedge clk);
      chk("t5_gap_rd", rd_cnt - r0, 0);
      chk("t5_gap_wr", 32'((wq.size() - w0) <= 1), 1);
      force_empty  = 1'b0;
      b_fifo_empty = (bq.size() == 0);
      wait_done("t5");
      check_out("t5", 32, 4'b0010, 8'h60);

      // Reset in the middle of a transfer clears outputs and the table.
      push_frame(MAC_A, MAC_C, 2'd0, 64, 8'h00);
      wait_writes("rm", 5);
      arst_n = 1'b0;
      hq.delete();
      bq.delete();
      h_fifo_empty = 1'b1;
      b_fifo_empty = 1'b1;
      #1;
      chk("rm_out", {h_fifo_rden, b_fifo_rden, o_fifo_wren, o_fifo_del, o_fifo_din, busy}, 0);
      chk("rm_drop", drop_cnt, 0);
      @(negedge clk);
      wq.delete();
      arst_n = 1'b1;
      repeat (2) @(negedge clk);
      push_frame(MAC_A, MAC_C, 2'd0, 8, 8'h70);
      wait_done("pr");
      check_out("pr", 8, 4'b1110, 8'h70);

`ifdef MAC_AGING_EN
      // Aging with AGE_TICKS=100: ticks on edges 100, 200, 300 after release.
      arst_n = 1'b0;
      @(negedge clk);
      arst_n = 1'b1;
      push_frame(MAC_B, 48'h0200_0000_0005, 2'd1, 4, 8'h11);
      wait_done("t6l");
      check_out("t6l", 4, 4'b1101, 8'h11);
      while (ecnt < 297) @(negedge clk);
      // Header visible for edge 298 -> LKUP write on edge 300, same as a tick.
      push_frame(MAC_B, 48'h0200_0000_0008, 2'd1, 4, 8'h22);
      wait_done("t6h");
      check_out("t6h", 4, 4'b1101, 8'h22);
      push_frame(48'h0200_0000_0005, MAC_C, 2'd0, 4, 8'h33);
      wait_done("t6a");
      check_out("t6a", 4, 4'b1110, 8'h33);
      push_frame(48'h0200_0000_0008, MAC_C, 2'd0, 4, 8'h44);
      wait_done("t6t");
      check_out("t6t", 4, 4'b0010, 8'h44);
      chk("t6_win", 32'(ecnt < 400), 1);
`endif

      chk("underrun", urun, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
